// File: rtl/det4x4_responder_if.sv
// det4x4_responder_if
//   Operand/result bundle between a determinant initiator and det4x4_responder.
//   start      : initiator -> responder, request pulse (sampled while responder idle)
//   a..p       : initiator -> responder, signed 8-bit matrix, row-major
//                (row0 = a b c d, row1 = e f g h, row2 = i j k l, row3 = m n o p)
//   resultado  : responder -> initiator, low 16 bits of the determinant
//   done       : responder -> initiator, result valid (level)
//   ovf        : responder -> initiator, determinant does not fit in 16 bits
interface det4x4_responder_if;
    logic               start;
    logic signed [7:0]  a, b, c, d;
    logic signed [7:0]  e, f, g, h;
    logic signed [7:0]  i, j, k, l;
    logic signed [7:0]  m, n, o, p;
    logic signed [15:0] resultado;
    logic               done;
    logic               ovf;

    modport master (
        output start,
        output a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
        input  resultado, done, ovf
    );

    modport slave (
        input  start,
        input  a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
        output resultado, done, ovf
    );
endinterface

// File: rtl/det4x4_responder.sv
// det4x4_responder
//   Sequential 4x4 determinant with a single signed 8x25 multiplier. A start seen
//   in idle latches the matrix; 40 calculation steps expand along row 0 (10 steps
//   per 3x3 minor), then one finish cycle publishes the result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of det4x4_responder_if (start, a..p in; resultado, done, ovf out)
module det4x4_responder (
    input logic                clk,
    input logic                rst_n,
    det4x4_responder_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e             state_q;
    logic [5:0]         step_q;
    logic signed [7:0]  mat_q [16];
    logic signed [16:0] t_q [3];
    logic signed [24:0] mnr_q;
    logic signed [35:0] acc_q;
    logic signed [15:0] res_q;
    logic               done_q;
    logic               ovf_q;

    // Step decode: minor index (0..3) and position within that minor (0..9).
    logic [1:0] minor;
    logic [3:0] sub;

    always_comb begin
        if (step_q >= 6'd30) begin
            minor = 2'd3;
            sub   = 4'(step_q - 6'd30);
        end else if (step_q >= 6'd20) begin
            minor = 2'd2;
            sub   = 4'(step_q - 6'd20);
        end else if (step_q >= 6'd10) begin
            minor = 2'd1;
            sub   = 4'(step_q - 6'd10);
        end else begin
            minor = 2'd0;
            sub   = 4'(step_q);
        end
    end

    // The three columns that survive when column `minor` is removed.
    logic [1:0] c0, c1, c2;
    assign c0 = (minor == 2'd0) ? 2'd1 : 2'd0;
    assign c1 = (minor <= 2'd1) ? 2'd2 : 2'd1;
    assign c2 = (minor <= 2'd2) ? 2'd3 : 2'd2;

    // Minor rows: x = row1, y = row2, z = row3.
    logic signed [7:0] x0, x1, x2, y0, y1, y2, z0, z1, z2, r0k;
    assign x0  = mat_q[{2'd1, c0}];
    assign x1  = mat_q[{2'd1, c1}];
    assign x2  = mat_q[{2'd1, c2}];
    assign y0  = mat_q[{2'd2, c0}];
    assign y1  = mat_q[{2'd2, c1}];
    assign y2  = mat_q[{2'd2, c2}];
    assign z0  = mat_q[{2'd3, c0}];
    assign z1  = mat_q[{2'd3, c1}];
    assign z2  = mat_q[{2'd3, c2}];
    assign r0k = mat_q[{2'd0, minor}];

    // Shared multiplier operand mux.
    logic signed [7:0]  mul_a;
    logic signed [24:0] mul_b;
    logic signed [32:0] prod;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (sub)
            4'd0: begin mul_a = y1;  mul_b = {{17{z2[7]}}, z2}; end
            4'd1: begin mul_a = y2;  mul_b = {{17{z1[7]}}, z1}; end
            4'd2: begin mul_a = y0;  mul_b = {{17{z2[7]}}, z2}; end
            4'd3: begin mul_a = y2;  mul_b = {{17{z0[7]}}, z0}; end
            4'd4: begin mul_a = y0;  mul_b = {{17{z1[7]}}, z1}; end
            4'd5: begin mul_a = y1;  mul_b = {{17{z0[7]}}, z0}; end
            4'd6: begin mul_a = x0;  mul_b = {{8{t_q[0][16]}}, t_q[0]}; end
            4'd7: begin mul_a = x1;  mul_b = {{8{t_q[1][16]}}, t_q[1]}; end
            4'd8: begin mul_a = x2;  mul_b = {{8{t_q[2][16]}}, t_q[2]}; end
            4'd9: begin mul_a = r0k; mul_b = mnr_q; end
            default: ;
        endcase
    end

    assign prod = mul_a * mul_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            for (int idx = 0; idx < 16; idx++) mat_q[idx] <= '0;
            for (int idx = 0; idx < 3; idx++)  t_q[idx]   <= '0;
            mnr_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        mat_q[0]  <= bus.a;  mat_q[1]  <= bus.b;
                        mat_q[2]  <= bus.c;  mat_q[3]  <= bus.d;
                        mat_q[4]  <= bus.e;  mat_q[5]  <= bus.f;
                        mat_q[6]  <= bus.g;  mat_q[7]  <= bus.h;
                        mat_q[8]  <= bus.i;  mat_q[9]  <= bus.j;
                        mat_q[10] <= bus.k;  mat_q[11] <= bus.l;
                        mat_q[12] <= bus.m;  mat_q[13] <= bus.n;
                        mat_q[14] <= bus.o;  mat_q[15] <= bus.p;
                        acc_q     <= '0;
                        step_q    <= '0;
                        done_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                        state_q   <= StCalc;
                    end
                end
                StCalc: begin
                    // Even/odd pairs build each 2x2 term: first product, then subtract.
                    case (sub)
                        4'd0: t_q[0] <= prod[16:0];
                        4'd1: t_q[0] <= t_q[0] - prod[16:0];
                        4'd2: t_q[1] <= prod[16:0];
                        4'd3: t_q[1] <= t_q[1] - prod[16:0];
                        4'd4: t_q[2] <= prod[16:0];
                        4'd5: t_q[2] <= t_q[2] - prod[16:0];
                        4'd6: mnr_q  <= prod[24:0];
                        4'd7: mnr_q  <= mnr_q - prod[24:0];
                        4'd8: mnr_q  <= mnr_q + prod[24:0];
                        4'd9: begin
                            // Odd minors (b, d) carry a negative cofactor sign.
                            if (minor[0]) acc_q <= acc_q - {{3{prod[32]}}, prod};
                            else          acc_q <= acc_q + {{3{prod[32]}}, prod};
                        end
                        default: ;
                    endcase
                    if (step_q == 6'd39) begin
                        step_q  <= '0;
                        state_q <= StFin;
                    end else begin
                        step_q  <= step_q + 6'd1;
                    end
                end
                StFin: begin
                    res_q   <= acc_q[15:0];
                    // Fits in 16 bits only if bits 35..15 are all sign copies.
                    ovf_q   <= !((&acc_q[35:15]) || !(|acc_q[35:15]));
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.resultado = res_q;
    assign bus.done      = done_q;
    assign bus.ovf       = ovf_q;

endmodule
